// File: rtl/mips_mem_port.sv
// Avalon-MM master port for the multicycle MIPS core.
// Runs one load/store at a time as a word-aligned bus cycle and answers
// with an extended read result or an error (misalignment, reserved size
// or an optional waitrequest timeout).
module mips_mem_port #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state, state_next;
  logic [1:0]              size_q, size_next;
  logic [1:0]              lane_q, lane_next;
  logic                    signed_q, signed_next;
  logic [CNT_W-1:0]        cnt, cnt_next;

  logic                    read_next, write_next;
  logic [ADDR_WIDTH-1:0]   address_next;
  logic [3:0]              be_next;
  logic [31:0]             wd_next;
  logic                    resp_valid_next, resp_err_next;
  logic [31:0]             resp_rdata_next;

  logic                    misaligned;
  logic [3:0]              lane_be;
  logic [31:0]             lane_wd;
  logic [31:0]             shifted;
  logic [31:0]             load_ext;
  logic                    timeout_hit;

  assign req_ready = (state == IDLE) && !reset;

  // Classify the incoming request and place its store data on the lanes
  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'b1111;
    lane_wd    = req_wdata;
    unique case (req_size)
      2'd0: begin
        lane_be = 4'b0001 << req_addr[1:0];
        lane_wd = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd    = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Pick the addressed lane(s) out of the bus word and extend them
  always_comb begin
    shifted = readdata >> {lane_q, 3'b000};
    unique case (size_q)
      2'd0:    load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = readdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next registered outputs; outputs hold unless changed
  always_comb begin
    state_next      = state;
    size_next       = size_q;
    lane_next       = lane_q;
    signed_next     = signed_q;
    cnt_next        = cnt;
    read_next       = read;
    write_next      = write;
    address_next    = address;
    be_next         = byteenable;
    wd_next         = writedata;
    resp_valid_next = 1'b0;
    resp_err_next   = resp_err;
    resp_rdata_next = resp_rdata;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          size_next   = req_size;
          lane_next   = req_addr[1:0];
          signed_next = req_signed;
          if (misaligned) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else begin
            state_next   = BUS;
            read_next    = !req_write;
            write_next   = req_write;
            address_next = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            be_next      = lane_be;
            wd_next      = lane_wd;
            cnt_next     = '0;
          end
        end
      end
      BUS: begin
        // completion is tested first so a same-edge release beats the timeout
        if (!waitrequest) begin
          state_next      = RESP;
          read_next       = 1'b0;
          write_next      = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b0;
          resp_rdata_next = read ? load_ext : '0;
        end else if (timeout_hit) begin
          state_next      = RESP;
          read_next       = 1'b0;
          write_next      = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
        end else if (TIMEOUT != 0) begin
          cnt_next = cnt + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= '0;
      lane_q     <= '0;
      signed_q   <= 1'b0;
      cnt        <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_next;
      size_q     <= size_next;
      lane_q     <= lane_next;
      signed_q   <= signed_next;
      cnt        <= cnt_next;
      read       <= read_next;
      write      <= write_next;
      address    <= address_next;
      byteenable <= be_next;
      writedata  <= wd_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
    end
  end

endmodule

// File: tb/tb_mips_mem_port.sv
// Directed bench for mips_mem_port with a behavioural expectation model
// and a per-cycle compare process.
module tb_mips_mem_port;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic        read, write, waitrequest;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  mips_mem_port #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'd0)      v = 32'd1 << (a % 4);
    else if (sz == 2'd1) v = 32'd3 << (a % 4);
    else                 v = 32'd15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] sz, input bit sg,
                                       input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- expectations shared with compare process ----------------
  bit          exp_bus = 0, exp_resp = 0, exp_wr = 0, exp_err = 0;
  logic [31:0] exp_addr = '0, exp_wd = '0, exp_rdata = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] hold_rdata = '0;
  bit          hold_err = 0;
  int          cyc = 0, strobe_cnt = 0, resp_cyc = 0;
  bit          resp_seen = 0;
  logic [3:0]  first_be;
  logic [31:0] first_wd;

  // Compare DUT outputs against the model every cycle, just after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("rw_exclusive", {31'd0, read & write}, 32'd0);
    if (read || write) begin
      strobe_cnt++;
      if (strobe_cnt == 1) begin
        first_be = byteenable;
        first_wd = writedata;
      end
      if (!exp_bus) chk("unexpected_strobe", 32'd1, 32'd0);
      else begin
        chk("address", address, exp_addr);
        chk("byteenable", {28'd0, byteenable}, {28'd0, exp_be});
        chk("write_strobe", {31'd0, write}, {31'd0, exp_wr});
        chk("read_strobe", {31'd0, read}, {31'd0, !exp_wr});
        if (exp_wr) chk("writedata", writedata, exp_wd);
      end
    end
    if (resp_valid) begin
      if (!exp_resp) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        hold_rdata = exp_rdata;
        hold_err   = exp_err;
        resp_seen  = 1;
        resp_cyc   = cyc;
        exp_resp   = 0;
      end
    end
    chk("rdata_hold", resp_rdata, hold_rdata);
    chk("err_hold", {31'd0, resp_err}, {31'd0, hold_err});
  end

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    bit          lit_rd_en;
    logic [31:0] lit_rd;
    bit          lit_err;
    bit          lit_bus_en;
    logic [3:0]  lit_be;
    logic [31:0] lit_wd;
  } vec_t;

  task automatic do_req(input vec_t v);
    bit mis, tmo;
    int exp_lat, acc;
    mis = m_mis(v.sz, v.a);
    tmo = !mis && (v.stall >= int'(TMO));
    exp_wr    = v.wr;
    exp_addr  = v.a & 32'hFFFF_FFFC;
    exp_be    = m_be(v.sz, v.a);
    exp_wd    = m_wd(v.sz, v.wd);
    exp_rdata = (mis || tmo || v.wr) ? 32'd0 : m_rd(v.sz, v.sg, v.a, v.rd);
    exp_err   = mis || tmo;
    exp_lat   = mis ? 0 : (tmo ? int'(TMO) : 1 + v.stall);
    exp_bus   = !mis;
    exp_resp  = 1;
    strobe_cnt = 0;
    resp_seen  = 0;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_write   = v.wr;
    req_size    = v.sz;
    req_signed  = v.sg;
    req_addr    = v.a;
    req_wdata   = v.wd;
    readdata    = v.rd;
    waitrequest = (v.stall > 0);
    req_valid   = 1'b1;
    @(posedge clk);
    #2;
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (v.stall) @(negedge clk);
    waitrequest = 1'b0;
    for (int i = 0; i < 40 && !resp_seen; i++) @(negedge clk);
    chk("resp_seen", {31'd0, resp_seen}, 32'd1);
    if (resp_seen) chk("latency", 32'(resp_cyc - acc), 32'(exp_lat));
    chk("strobe_cycles", 32'(strobe_cnt), 32'(mis ? 0 : exp_lat));
    if (v.lit_rd_en) begin
      chk("lit_rdata", resp_rdata, v.lit_rd);
      chk("lit_err", {31'd0, resp_err}, {31'd0, v.lit_err});
    end
    if (v.lit_bus_en) begin
      chk("lit_be", {28'd0, first_be}, {28'd0, v.lit_be});
      chk("lit_wd", first_wd, v.lit_wd);
    end
    exp_bus  = 0;
    exp_resp = 0;
    for (int i = 0; i < 5 && !req_ready; i++) @(negedge clk);
    chk("ready_return", {31'd0, req_ready}, 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; waitrequest = 0; readdata = 0;

    //          wr sz sg addr          wdata         rdata        st lr litrd        le lb be       wd
    vecs[0]  = '{0, 0, 1, 32'h1003, 32'h0,        32'h80FF1234, 0, 1, 32'hFFFFFF80, 0, 1, 4'b1000, 32'h0};
    vecs[1]  = '{1, 1, 0, 32'h2002, 32'h0000BEEF, 32'h0,        3, 1, 32'h0,        0, 1, 4'b1100, 32'hBEEFBEEF};
    vecs[2]  = '{0, 2, 0, 32'h0002, 32'h0,        32'h11111111, 0, 1, 32'h0,        1, 0, 4'h0,    32'h0};
    vecs[3]  = '{0, 2, 0, 32'h0010, 32'h0,        32'h22222222, 10,1, 32'h0,        1, 0, 4'h0,    32'h0};
    vecs[4]  = '{0, 2, 0, 32'h0014, 32'h0,        32'h12345678, 0, 1, 32'h12345678, 0, 1, 4'b1111, 32'h0};
    vecs[5]  = '{0, 1, 0, 32'h0006, 32'h0,        32'h9ABC5678, 0, 1, 32'h00009ABC, 0, 1, 4'b1100, 32'h0};
    vecs[6]  = '{0, 1, 1, 32'h0004, 32'h0,        32'h12348001, 1, 1, 32'hFFFF8001, 0, 0, 4'h0,    32'h0};
    vecs[7]  = '{0, 0, 0, 32'h0001, 32'h0,        32'h0000AB00, 0, 1, 32'h000000AB, 0, 1, 4'b0010, 32'h0};
    vecs[8]  = '{1, 0, 0, 32'h0102, 32'h0000005A, 32'h0,        2, 0, 32'h0,        0, 1, 4'b0100, 32'h5A5A5A5A};
    vecs[9]  = '{1, 2, 0, 32'h0200, 32'hDEADBEEF, 32'h0,        1, 1, 32'h0,        0, 1, 4'b1111, 32'hDEADBEEF};
    vecs[10] = '{0, 3, 0, 32'h0000, 32'h0,        32'h33333333, 0, 1, 32'h0,        1, 0, 4'h0,    32'h0};
    vecs[11] = '{0, 1, 1, 32'h0001, 32'h0,        32'h44444444, 0, 1, 32'h0,        1, 0, 4'h0,    32'h0};
    vecs[12] = '{0, 2, 0, 32'h0020, 32'h0,        32'hCAFEF00D, 3, 1, 32'hCAFEF00D, 0, 0, 4'h0,    32'h0};
    vecs[13] = '{0, 0, 1, 32'h0002, 32'h0,        32'h00550000, 0, 1, 32'h00000055, 0, 0, 4'h0,    32'h0};

    repeat (3) @(negedge clk);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_req(vecs[i]);

    // reset in the middle of a stalled load
    exp_wr = 0; exp_addr = 32'h300; exp_be = 4'b1111; exp_bus = 1; exp_resp = 0;
    req_write = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h300;
    waitrequest = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("read_before_reset", {31'd0, read}, 32'd1);
    hold_rdata = '0;
    hold_err   = 0;
    exp_bus    = 0;
    reset = 1'b1;
    #1;
    chk("read_async_drop", {31'd0, read}, 32'd0);
    chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    #1;
    chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    do_req(vecs[4]);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
